// File: rtl/banco_de_registradores_if.sv
// Bus bundle for the 64x32 register bank: read/write addresses, write
// controls and the three combinational read ports.
`default_nettype none

interface banco_de_registradores_if;
  logic [5:0]  RS;
  logic [5:0]  RT;
  logic [5:0]  RD;
  logic [31:0] SPIn;
  logic [31:0] DadoEscrito;
  logic        RegWrite;
  logic        NOP;
  logic        StackOP;
  logic        JAL;
  logic [31:0] dado1;
  logic [31:0] dado2;
  logic [31:0] SPOut;

  modport master (
    output RS, RT, RD, SPIn, DadoEscrito, RegWrite, NOP, StackOP, JAL,
    input  dado1, dado2, SPOut
  );

  modport slave (
    input  RS, RT, RD, SPIn, DadoEscrito, RegWrite, NOP, StackOP, JAL,
    output dado1, dado2, SPOut
  );
endinterface

`default_nettype wire

// File: rtl/banco_de_registradores.sv
// ============================================================================
// Module      : banco_de_registradores
// Description : 64 x 32-bit register file, two async read ports, dedicated
//               stack-pointer register with its own write path, JAL link write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module banco_de_registradores #(
  parameter int          SP_INDEX = 29,
  parameter int          RA_INDEX = 31,
  parameter logic [31:0] SP_RESET = 32'd1023
) (
  input  wire                       clock,
  input  wire                       reset,
  banco_de_registradores_if.slave   bus
);

  localparam logic [5:0] c_sp_idx = 6'(SP_INDEX);
  localparam logic [5:0] c_ra_idx = 6'(RA_INDEX);

  logic [31:0] r_regs [0:63];
  logic [5:0]  w_dest;

  assign w_dest = bus.JAL ? c_ra_idx : bus.RD;

  // The stack-pointer write is issued last so it wins a same-edge collision
  // with a normal write to the SP register.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) begin
        r_regs[i] <= ((i == SP_INDEX) && (SP_INDEX != 0)) ? SP_RESET : 32'd0;
      end
    end else if (!bus.NOP) begin
      if (bus.RegWrite && (w_dest != 6'd0)) begin
        r_regs[w_dest] <= bus.DadoEscrito;
      end
      if (bus.StackOP && (c_sp_idx != 6'd0)) begin
        r_regs[c_sp_idx] <= bus.SPIn;
      end
    end
  end

  assign bus.dado1 = (bus.RS == 6'd0) ? 32'd0 : r_regs[bus.RS];
  assign bus.dado2 = (bus.RT == 6'd0) ? 32'd0 : r_regs[bus.RT];
  assign bus.SPOut = (c_sp_idx == 6'd0) ? 32'd0 : r_regs[c_sp_idx];

endmodule

`default_nettype wire

// File: tb/tb_banco_de_registradores.sv
// Scoreboard bench for banco_de_registradores: a driver pushes expected read
// values from an array model, a negedge monitor pops and compares.
`default_nettype none

module tb_banco_de_registradores;

  localparam int          SP  = 29;
  localparam int          RA  = 31;
  localparam logic [31:0] SPR = 32'd1023;

  logic clock = 1'b0;
  logic reset;

  banco_de_registradores_if bus ();

  banco_de_registradores #(
    .SP_INDEX(SP),
    .RA_INDEX(RA),
    .SP_RESET(SPR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] sp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mreg[64];
  bit          model_known = 0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] mread(input logic [5:0] a);
    return (a == 6'd0) ? 32'd0 : mreg[a];
  endfunction

  // One clock of stimulus: drive, record what the outputs must show before
  // the coming edge, then advance the model by that edge's writes.
  task automatic step(input bit rst, input bit nop, input bit rw, input bit sop,
                      input bit jal, input logic [5:0] rd, input logic [31:0] din,
                      input logic [31:0] spin, input logic [5:0] rs,
                      input logic [5:0] rt);
    exp_t e;
    int   dest;
    @(posedge clock);
    #1;
    reset           = rst;
    bus.NOP         = nop;
    bus.RegWrite    = rw;
    bus.StackOP     = sop;
    bus.JAL         = jal;
    bus.RD          = rd;
    bus.DadoEscrito = din;
    bus.SPIn        = spin;
    bus.RS          = rs;
    bus.RT          = rt;
    if (model_known) begin
      e.rs = rs; e.rt = rt;
      e.d1 = mread(rs); e.d2 = mread(rt); e.sp = mread(6'(SP));
      sb.push_back(e);
    end
    if (rst) begin
      foreach (mreg[i]) mreg[i] = 32'd0;
      mreg[SP]    = SPR;
      model_known = 1;
    end else if (!nop && model_known) begin
      dest = jal ? RA : int'(rd);
      if (rw) mreg[dest] = din;
      if (sop) mreg[SP] = spin;
      mreg[0] = 32'd0;
    end
  endtask

  task automatic rd2(input logic [5:0] rs, input logic [5:0] rt);
    step(0, 0, 0, 0, 0, 6'd0, 32'd0, 32'd0, rs, rt);
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks += 3;
      if (bus.dado1 !== e.d1) begin
        errors++;
        $display("FAIL dado1 RS=%0d: got %h expected %h", e.rs, bus.dado1, e.d1);
      end
      if (bus.dado2 !== e.d2) begin
        errors++;
        $display("FAIL dado2 RT=%0d: got %h expected %h", e.rt, bus.dado2, e.d2);
      end
      if (bus.SPOut !== e.sp) begin
        errors++;
        $display("FAIL SPOut: got %h expected %h", bus.SPOut, e.sp);
      end
    end
  end

  initial begin
    int budget;
    reset = 1'b1;
    bus.NOP = 0; bus.RegWrite = 0; bus.StackOP = 0; bus.JAL = 0;
    bus.RD = '0; bus.DadoEscrito = '0; bus.SPIn = '0; bus.RS = '0; bus.RT = '0;

    step(1, 0, 0, 0, 0, 6'd0, 32'd0, 32'd0, 6'd0, 6'd0);
    rd2(6'd3, 6'd29);
    rd2(6'd63, 6'd1);
    // write then read back on both ports
    step(0, 0, 1, 0, 0, 6'd3, 32'd7, 32'd0, 6'd3, 6'd3);
    rd2(6'd3, 6'd3);
    // register zero discards writes
    step(0, 0, 1, 0, 0, 6'd0, 32'hFFFF_FFFF, 32'd0, 6'd0, 6'd0);
    rd2(6'd0, 6'd0);
    // JAL redirects to RA; JAL without RegWrite writes nothing
    step(0, 0, 1, 0, 1, 6'd5, 32'h40, 32'd0, 6'd31, 6'd5);
    rd2(6'd31, 6'd5);
    step(0, 0, 0, 0, 1, 6'd6, 32'h55, 32'd0, 6'd31, 6'd6);
    rd2(6'd31, 6'd6);
    // StackOP beats a same-edge write to the SP register
    step(0, 0, 0, 1, 0, 6'd0, 32'd0, 32'd1019, 6'd29, 6'd0);
    step(0, 0, 1, 1, 0, 6'd29, 32'd5, 32'd1019, 6'd29, 6'd0);
    rd2(6'd29, 6'd29);
    // StackOP and a write elsewhere both land
    step(0, 0, 1, 1, 0, 6'd10, 32'h1234, 32'd800, 6'd10, 6'd29);
    rd2(6'd10, 6'd29);
    // NOP blocks everything
    step(0, 1, 1, 1, 1, 6'd4, 32'd9, 32'd1, 6'd4, 6'd31);
    step(0, 1, 1, 1, 0, 6'd4, 32'd9, 32'd1, 6'd4, 6'd31);
    rd2(6'd4, 6'd31);
    // read-during-write returns the old value
    step(0, 0, 1, 0, 0, 6'd8, 32'hA5A5, 32'd0, 6'd8, 6'd8);
    rd2(6'd8, 6'd3);
    // reset overrides a same-edge write
    step(1, 0, 1, 1, 0, 6'd7, 32'h77, 32'd3, 6'd3, 6'd10);
    rd2(6'd3, 6'd7);
    rd2(6'd10, 6'd31);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63))),
           $urandom(), $urandom(),
           ($urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63))),
           ($urandom_range(0, 3) == 0 ? 6'(SP) : 6'($urandom_range(0, 63))));
    end
    rd2(6'd0, 6'd29);

    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge clock);
      budget++;
    end
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/banco_de_registradores.md
BANCO_DE_REGISTRADORES -- requirements
Module: banco_de_registradores

Interface
REQ-001 Parameter SP_INDEX, default 29, register index that holds the stack pointer.
REQ-002 Parameter RA_INDEX, default 31, register index that receives the JAL link value.
REQ-003 Parameter SP_RESET, default 32'd1023, value loaded into register SP_INDEX on reset.
REQ-004 Port clock, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port RS, input, 6 bits: read address for dado1.
REQ-007 Port RT, input, 6 bits: read address for dado2.
REQ-008 Port RD, input, 6 bits: write address for normal writes.
REQ-009 Port SPIn, input, 32 bits: new stack pointer value.
REQ-010 Port DadoEscrito, input, 32 bits: write data.
REQ-011 Port RegWrite, input, 1 bit: write enable.
REQ-012 Port NOP, input, 1 bit: suppresses all writes.
REQ-013 Port StackOP, input, 1 bit: loads SPIn into the SP register.
REQ-014 Port JAL, input, 1 bit: redirects the write destination to RA_INDEX.
REQ-015 Port dado1, output, 32 bits: contents of register RS.
REQ-016 Port dado2, output, 32 bits: contents of register RT.
REQ-017 Port SPOut, output, 32 bits: contents of register SP_INDEX.

Function
REQ-018 Storage SHALL be 64 registers of 32 bits, indices 0-63.
REQ-019 Reads SHALL be combinational and asynchronous: dado1 = reg[RS], dado2 = reg[RT], SPOut = reg[SP_INDEX].
REQ-020 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded, including via StackOP if SP_INDEX = 0.
REQ-021 At a rising edge with reset=0, NOP=0, RegWrite=1: destination = RA_INDEX if JAL=1, else RD; destination <= DadoEscrito.
REQ-022 JAL=1 with RegWrite=0 SHALL write nothing.
REQ-023 At a rising edge with reset=0, NOP=0, StackOP=1: reg[SP_INDEX] <= SPIn, independent of RegWrite.
REQ-024 Simultaneous StackOP and a RegWrite write to SP_INDEX: the StackOP write (SPIn) SHALL win.
REQ-025 Simultaneous StackOP and a RegWrite write to a different index: both writes SHALL occur in the same edge.
REQ-026 NOP=1 SHALL block every write (RegWrite, JAL, StackOP) on that edge; reads are unaffected.
REQ-027 Write latency is one edge: a written value SHALL appear on the outputs immediately after that edge.
REQ-028 Read-during-write to the same index SHALL return the old value until the edge (no bypass).
REQ-029 Register contents SHALL be held indefinitely when no write is enabled.

Reset
REQ-030 On a rising edge with reset=1: all registers <= 0, except reg[SP_INDEX] <= SP_RESET.
REQ-031 reset SHALL override NOP, RegWrite, StackOP and JAL.
REQ-032 Immediately after reset: dado1 = dado2 = 0 for all addresses except SP_INDEX, and SPOut = SP_RESET.

Verification
REQ-033 Write then read: reset; RD=3, DadoEscrito=7, RegWrite=1, one edge; then RegWrite=0, RS=3 -> dado1=7, and dado2=7 when RT=3.
REQ-034 Zero register: RD=0, DadoEscrito=32'hFFFF_FFFF, RegWrite=1, one edge -> reading RS=0 gives 0.
REQ-035 JAL: JAL=1, RegWrite=1, RD=5, DadoEscrito=32'h40, one edge -> reg[31]=32'h40, reg[5] unchanged (0).
REQ-036 Stack pointer: after reset SPOut=1023; StackOP=1, SPIn=1019 -> SPOut=1019 after the edge; with RegWrite=1, RD=29, DadoEscrito=5 on the same edge -> SPOut=1019.
REQ-037 NOP: NOP=1, RegWrite=1, StackOP=1, RD=4, DadoEscrito=9 -> reg[4] stays 0 and SPOut is unchanged.
REQ-038 Reset mid-operation: after nonzero writes, reset=1 with RegWrite=1 on the same edge -> all registers 0 and SPOut=1023.
